// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle controller: FSM states,
// opcode classes, opcode encodings, ALU operation codes and B-source selects.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_e;

  typedef enum logic [2:0] {
    CL_RTYPE,
    CL_IALU,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_ILLEGAL
  } op_class_e;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1100;

  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  function automatic op_class_e classify(input logic [6:0] op);
    case (op)
      OP_RTYPE:  return CL_RTYPE;
      OP_IALU:   return CL_IALU;
      OP_LOAD:   return CL_LOAD;
      OP_STORE:  return CL_STORE;
      OP_BRANCH: return CL_BRANCH;
      default:   return CL_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/mc_if.sv
// Controller bus: instruction fields and status in, memory handshake and
// datapath control strobes out. master = controller side, slave = datapath side.
interface mc_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             ir_write;
  logic             pc_write;
  logic             pc_src;
  logic [1:0]       alu_src_b;
  logic             reg_write;
  logic             mem2reg;
  logic [3:0]       alu_cc;
  logic             illegal;
  logic             instr_done;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    input  opcode, funct3, funct7, zero, mem_ready,
    output mem_req, mem_we, ir_write, pc_write, pc_src, alu_src_b,
           reg_write, mem2reg, alu_cc, illegal, instr_done, retire_cnt
  );

  modport slave (
    output opcode, funct3, funct7, zero, mem_ready,
    input  mem_req, mem_we, ir_write, pc_write, pc_src, alu_src_b,
           reg_write, mem2reg, alu_cc, illegal, instr_done, retire_cnt
  );
endinterface

// File: rtl/mc_alu_decode.sv
// Combinational funct3/funct7 to ALU operation map; SUB only when sub_en_i
// (R-type), undefined funct3 codes fall back to ADD.
module mc_alu_decode
  import mc_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic       sub_en_i,
  output logic [3:0] alu_cc_o
);

  always_comb begin
    alu_cc_o = ALU_ADD;
    case (funct3_i)
      3'b000:  alu_cc_o = (sub_en_i && funct7_i == 7'b0100000) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_cc_o = ALU_AND;
      3'b110:  alu_cc_o = ALU_OR;
      3'b100:  alu_cc_o = ALU_XOR;
      3'b010:  alu_cc_o = ALU_SLT;
      default: alu_cc_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with sticky trap and retire
// counter. Define MC_MEM_TIMEOUT_EN to trap after TIMEOUT_CYCLES stalled requests.
module mc_controller
  import mc_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic  clk,
  input logic  reset,
  mc_if.master bus
);

  if (CNT_W > XLEN || CNT_W < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mc_controller: CNT_W must be 1..XLEN and TIMEOUT_CYCLES >= 1");
  end

  state_e           state_q, state_d;
  op_class_e        cls_q, cls_d;
  logic             mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic             pc_src_q, pc_src_d, reg_write_q, reg_write_d;
  logic             mem2reg_q, mem2reg_d, illegal_q, illegal_d;
  logic [1:0]       srcb_q, srcb_d;
  logic [3:0]       alu_cc_q, alu_cc_d, dec_cc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_xfer, tmo_hit, branch_exec, ir_write, instr_done;

  // The class is latched in DECODE so later states do not depend on the IR.
  assign cls_d    = (state_q == ST_DECODE) ? classify(bus.opcode) : cls_q;
  assign mem_xfer = mem_req_q & bus.mem_ready;

  mc_alu_decode u_alu_decode (
    .funct3_i (bus.funct3),
    .funct7_i (bus.funct7),
    .sub_en_i (cls_d == CL_RTYPE),
    .alu_cc_o (dec_cc)
  );

`ifdef MC_MEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic             mem_stall;
  logic [TMO_W-1:0] tmo_q;

  assign mem_stall = mem_req_q & ~bus.mem_ready;
  assign tmo_hit   = mem_stall && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset)                   tmo_q <= '0;
    else if (mem_stall && !tmo_hit) tmo_q <= tmo_q + TMO_W'(1);
    else                          tmo_q <= '0;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (mem_xfer) state_d = ST_DECODE;
      ST_DECODE: state_d = (cls_d == CL_ILLEGAL) ? ST_TRAP : ST_EXEC;
      ST_EXEC: begin
        case (cls_q)
          CL_RTYPE, CL_IALU: state_d = ST_WB;
          CL_LOAD, CL_STORE: state_d = ST_MEM;
          default:           state_d = ST_FETCH;
        endcase
      end
      ST_MEM:    if (mem_xfer) state_d = (cls_q == CL_LOAD) ? ST_WB : ST_FETCH;
      ST_WB:     state_d = ST_FETCH;
      ST_TRAP:   state_d = ST_TRAP;
      default:   state_d = ST_FETCH;
    endcase
    if (tmo_hit) state_d = ST_TRAP;
  end

  // Moore outputs are computed for the state being entered and registered.
  always_comb begin
    mem_req_d   = (state_d == ST_FETCH) || (state_d == ST_MEM);
    mem_we_d    = (state_d == ST_MEM) && (cls_d == CL_STORE);
    pc_src_d    = (state_d == ST_EXEC) && (cls_d == CL_BRANCH);
    reg_write_d = (state_d == ST_WB);
    mem2reg_d   = (state_d == ST_WB) && (cls_d == CL_LOAD);
    illegal_d   = (state_d == ST_TRAP);
    srcb_d      = SRCB_REG;
    alu_cc_d    = ALU_ADD;
    if (state_d == ST_FETCH) begin
      srcb_d = SRCB_FOUR;
    end else if (state_d == ST_EXEC) begin
      case (cls_d)
        CL_RTYPE:          alu_cc_d = dec_cc;
        CL_IALU: begin
          srcb_d   = SRCB_IMM;
          alu_cc_d = dec_cc;
        end
        CL_LOAD, CL_STORE: srcb_d = SRCB_IMM;
        CL_BRANCH:         alu_cc_d = ALU_SUB;
        default:           alu_cc_d = ALU_ADD;
      endcase
    end
  end

  assign branch_exec = (state_q == ST_EXEC) && (cls_q == CL_BRANCH);
  assign ir_write    = (state_q == ST_FETCH) && mem_xfer;
  assign instr_done  = (state_q == ST_WB) || branch_exec ||
                       ((state_q == ST_MEM) && (cls_q == CL_STORE) && mem_xfer);
  assign cnt_d       = cnt_q + CNT_W'(instr_done);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_FETCH;
      cls_q       <= CL_ILLEGAL;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      pc_src_q    <= 1'b0;
      reg_write_q <= 1'b0;
      mem2reg_q   <= 1'b0;
      illegal_q   <= 1'b0;
      srcb_q      <= SRCB_REG;
      alu_cc_q    <= ALU_ADD;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      pc_src_q    <= pc_src_d;
      reg_write_q <= reg_write_d;
      mem2reg_q   <= mem2reg_d;
      illegal_q   <= illegal_d;
      srcb_q      <= srcb_d;
      alu_cc_q    <= alu_cc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.ir_write   = ir_write;
  assign bus.pc_write   = ir_write | (branch_exec & bus.zero);
  assign bus.pc_src     = pc_src_q;
  assign bus.alu_src_b  = srcb_q;
  assign bus.reg_write  = reg_write_q;
  assign bus.mem2reg    = mem2reg_q;
  assign bus.alu_cc     = alu_cc_q;
  assign bus.illegal    = illegal_q;
  assign bus.instr_done = instr_done;
  assign bus.retire_cnt = cnt_q;

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; it only sizes the retire counter ceiling check.
REQ-002 SHALL have parameter CNT_W, default 32, retire counter width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, memory-wait limit when MC_MEM_TIMEOUT_EN is defined.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-006 SHALL have port opcode  in  7  instruction opcode from the instruction register.
REQ-007 SHALL have port funct3  in  3  instruction funct3.
REQ-008 SHALL have port funct7  in  7  instruction funct7.
REQ-009 SHALL have port zero  in  1  ALU zero flag, sampled in EXEC.
REQ-010 SHALL have port mem_ready  in  1  memory handshake acknowledge.
REQ-011 SHALL have port mem_req  out  1  memory request, held until mem_ready.
REQ-012 SHALL have port mem_we  out  1  store qualifier, valid only with mem_req.
REQ-013 SHALL have port ir_write  out  1  instruction register load strobe.
REQ-014 SHALL have port pc_write  out  1  PC update strobe.
REQ-015 SHALL have port pc_src  out  1  PC source: 0 = PC+4, 1 = branch target.
REQ-016 SHALL have port alu_src_b  out  2  ALU B select: 0 = register, 1 = immediate, 2 = constant 4.
REQ-017 SHALL have port reg_write / mem2reg  out  1 each  register-file write enable / load-data writeback select.
REQ-018 SHALL have port alu_cc  out  4  ALU op: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, XOR 1100.
REQ-019 SHALL have ports illegal  out  1 (sticky trap flag), instr_done  out  1 (one-cycle retire pulse), retire_cnt  out  CNT_W (retired-instruction count).

Function
REQ-020 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-021 FETCH: mem_req=1, mem_we=0; on mem_ready, SHALL assert ir_write and pc_write (pc_src=0) for that cycle, then go to DECODE; otherwise SHALL stay in FETCH.
REQ-022 DECODE: SHALL take one cycle and go to EXEC for opcodes 0110011, 0010011, 0000011, 0100011, 1100011; any other opcode SHALL go to TRAP.
REQ-023 EXEC R-type (0110011): alu_src_b=0, alu_cc from funct3/funct7 (000/0000000 ADD, 000/0100000 SUB, 111 AND, 110 OR, 100 XOR, 010 SLT); next state WB.
REQ-024 EXEC I-ALU (0010011): alu_src_b=1; same funct3 map, with funct7 ignored (no SUB); next state WB.
REQ-025 EXEC load/store: alu_src_b=1, alu_cc=ADD; next state MEM.
REQ-026 EXEC branch (beq): alu_cc=SUB, alu_src_b=0; pc_write=zero, pc_src=1; instr_done=1; next state FETCH.
REQ-027 MEM: mem_req=1 and mem_we=1 for store; waits while mem_ready=0; load SHALL go to WB; store SHALL pulse instr_done and go to FETCH.
REQ-028 WB: reg_write=1, mem2reg=1 for loads only; instr_done=1; next state FETCH.
REQ-029 Latency with mem_ready tied high: R/I 4 cycles, load 5, store 4, branch 3; each mem_ready stall adds 1.
REQ-030 retire_cnt SHALL increment on every instr_done and wrap from all-ones to 0.
REQ-031 TRAP SHALL hold illegal=1, with all strobes 0 and retire_cnt frozen, until reset.
REQ-032 Outside their named states, all strobes SHALL be 0; alu_cc SHALL default to ADD.

Reset
REQ-033 While reset=0 at a clock edge, the block SHALL enter FETCH, clear retire_cnt, illegal and the timeout counter, and drive all strobes to 0, aborting any pending memory wait.
REQ-034 The first mem_req SHALL assert in the first cycle after reset returns high.

Configuration
REQ-035 With MC_MEM_TIMEOUT_EN defined, a counter SHALL count consecutive mem_req cycles with mem_ready=0; on reaching TIMEOUT_CYCLES the block SHALL enter TRAP with illegal=1; the counter SHALL clear on mem_ready.
REQ-036 Without MC_MEM_TIMEOUT_EN, the block SHALL wait indefinitely, and TIMEOUT_CYCLES SHALL be unused.

Structure
REQ-037 Package mc_pkg SHALL hold the state enum, the opcode constants and the alu_cc constants.
REQ-038 The funct3/funct7-to-alu_cc decode SHALL be the combinational sub-module mc_alu_decode; the FSM, timeout and counter SHALL remain in mc_controller.

Verification
REQ-039 add x (0110011/000/0000000), mem_ready=1 -> FETCH,DECODE,EXEC(alu_cc=0010),WB(reg_write=1); instr_done at cycle 4; retire_cnt=1.
REQ-040 Load with mem_ready low for 3 MEM cycles -> mem_req held 3 cycles, then WB with mem2reg=1; total 8 cycles.
REQ-041 beq with zero=1, then with zero=0 -> pc_write=1/pc_src=1 in EXEC, then pc_write=0; each takes 3 cycles.
REQ-042 opcode 1111111 -> TRAP after DECODE, illegal=1 and sticky; reset=0 for one edge -> FETCH, illegal=0.
REQ-043 With MC_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=16, mem_ready stuck at 0 in FETCH -> TRAP after 16 cycles; without the macro, still in FETCH after 100 cycles.
REQ-044 CNT_W=4: retire 17 instructions -> retire_cnt=1 (wrap).
